// File: rtl/mul_frame_pkg.sv
// Shared sizing and state encodings for the frame multiply-accumulate block.
package mul_frame_pkg;

    localparam int MUL_MAX_LEN = 16;
    // 16 * 225 = 3600 fits in 12 bits.
    localparam int MUL_ACC_W   = 12;
    localparam int MUL_CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/tt_um_mul_addtree.sv
// Combinational 4x4 unsigned multiplier built as a two-level add tree of partial products.
module tt_um_mul_addtree (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s01, s23;

    // Shifted partial products, summed pairwise and then together.
    always_comb begin
        pp0 = b[0] ? {4'b0000, a}        : 8'd0;
        pp1 = b[1] ? {3'b000, a, 1'b0}   : 8'd0;
        pp2 = b[2] ? {2'b00, a, 2'b00}   : 8'd0;
        pp3 = b[3] ? {1'b0, a, 3'b000}   : 8'd0;
        s01 = pp0 + pp1;
        s23 = pp2 + pp3;
        p   = s01 + s23;
    end

endmodule

// File: rtl/mul_frame_acc.sv
// Frame multiply-accumulate: sums a*b over a frame of up to MAX_LEN beats
// through an operand / product / accumulate pipeline, then holds the result
// until the consumer takes it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ACCUM    | accepting beats, products trickling into the accumulator
// DRAIN    | terminating beat accepted, waiting for it to reach the adder
// HOLD     | result valid and frozen until out_ready
module mul_frame_acc
    import mul_frame_pkg::*;
#(
    parameter int MAX_LEN = MUL_MAX_LEN,
    parameter int ACC_W   = MUL_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_a,
    input  logic [3:0]           in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [MUL_CNT_W-1:0] out_count,
    output logic                 out_trunc
);

    state_e                 state_q, state_d;
    logic [3:0]             a_q, a_d, b_q, b_d;
    logic                   s1_vld_q, s1_vld_d, s1_term_q, s1_term_d;
    logic [7:0]             prod_q, prod_d;
    logic                   s2_vld_q, s2_vld_d, s2_term_q, s2_term_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [MUL_CNT_W-1:0]   count_q, count_d;
    logic                   trunc_q, trunc_d;
    logic                   out_valid_q, out_valid_d;

    logic [7:0]             prod_w;
    logic                   accept;
    logic                   at_max;
    logic                   term;

    tt_um_mul_addtree u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod_w)
    );

    // Ready only in ACCUM and never while reset is asserted.
    assign in_ready  = (state_q == ST_ACCUM) && !rst;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_trunc = trunc_q;

    // Next-state: pipeline advance, accumulate, and frame sequencing.
    always_comb begin
        accept = in_valid && in_ready;
        at_max = (count_q == MUL_CNT_W'(MAX_LEN - 1));
        term   = in_last || at_max;

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        count_d     = count_q;
        trunc_d     = trunc_q;
        out_valid_d = out_valid_q;

        s1_vld_d  = accept;
        s1_term_d = accept && term;
        if (accept) begin
            a_d = in_a;
            b_d = in_b;
        end

        s2_vld_d  = s1_vld_q;
        s2_term_d = s1_term_q;
        prod_d    = s1_vld_q ? prod_w : prod_q;

        acc_d = s2_vld_q ? (acc_q + ACC_W'(prod_q)) : acc_q;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    count_d = count_q + MUL_CNT_W'(1);
                    if (term) begin
                        // A frame closed by length alone is truncated; in_last wins on the last slot.
                        trunc_d = !in_last;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (s2_vld_q && s2_term_q) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    trunc_d     = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            a_q         <= '0;
            b_q         <= '0;
            s1_vld_q    <= 1'b0;
            s1_term_q   <= 1'b0;
            prod_q      <= '0;
            s2_vld_q    <= 1'b0;
            s2_term_q   <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s1_vld_q    <= s1_vld_d;
            s1_term_q   <= s1_term_d;
            prod_q      <= prod_d;
            s2_vld_q    <= s2_vld_d;
            s2_term_q   <= s2_term_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            trunc_q     <= trunc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mul_frame_acc.sv
// Bench for mul_frame_acc: directed frame table, corner sequences, and a
// randomized run checked by a frame-level reference model.
module tb_mul_frame_acc;
    import mul_frame_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [3:0]             in_a = 4'd0;
    logic [3:0]             in_b = 4'd0;
    logic                   in_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [MUL_ACC_W-1:0]   out_sum;
    logic [MUL_CNT_W-1:0]   out_count;
    logic                   out_trunc;

    int checks = 0;
    int failures = 0;

    mul_frame_acc #(.MAX_LEN(16), .ACC_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- frame-level reference model ----------------
    // Accepts a beat whenever no result is pending; a result becomes visible
    // three cycles after its terminating beat and stays until taken.
    int  m_sum = 0, m_cnt = 0, m_age = 0;
    bit  m_busy = 1'b0;
    int  r_sum = 0, r_cnt = 0;
    bit  r_trunc = 1'b0;
    bit  mon_exp_ov;
    int  m_frames = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_sum = 0; m_cnt = 0; m_age = 0;
        end else begin
            if (m_busy) m_age++;
            mon_exp_ov = m_busy && (m_age >= 3);
            check("mon_in_ready", in_ready, !m_busy);
            check("mon_out_valid", out_valid, mon_exp_ov);
            if (mon_exp_ov) begin
                check("mon_out_sum", out_sum, r_sum);
                check("mon_out_count", out_count, r_cnt);
                check("mon_out_trunc", out_trunc, r_trunc);
            end
            if (mon_exp_ov && out_ready) begin
                m_busy = 1'b0;
                m_frames++;
            end else if (!m_busy && in_valid) begin
                m_sum += int'(in_a) * int'(in_b);
                m_cnt++;
                if (in_last || m_cnt == 16) begin
                    r_sum = m_sum; r_cnt = m_cnt; r_trunc = !in_last;
                    m_busy = 1'b1; m_age = 0; m_sum = 0; m_cnt = 0;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        int          sum;
        int          cnt;
    } vec_t;

    vec_t tbl[5];

    // Called right after the edge that took the terminating beat.
    task automatic expect_result(input string nm, input int sum, input int cnt, input bit tr);
        check({nm, "_ov_t1"}, out_valid, 0);
        step();
        check({nm, "_ov_t2"}, out_valid, 0);
        step();
        check({nm, "_ov_t3"}, out_valid, 1);
        check({nm, "_sum"}, out_sum, sum);
        check({nm, "_count"}, out_count, cnt);
        check({nm, "_trunc"}, out_trunc, tr);
        check({nm, "_in_ready_hold"}, in_ready, 0);
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({nm, "_ready_after"}, in_ready, 1);
        check({nm, "_ov_after"}, out_valid, 0);
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_a     = v.a[4*i +: 4];
            in_b     = v.b[4*i +: 4];
            in_last  = (i == v.n - 1);
            check("b2b_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_uniform(input int n, input logic [3:0] a, input logic [3:0] b, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            in_last  = last_on_final && (i == n - 1);
            check("uni_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{n: 3, a: 16'h02F3, b: 16'h07F5, sum: 254, cnt: 3};
        tbl[1] = '{n: 1, a: 16'h0009, b: 16'h0009, sum: 81,  cnt: 1};
        tbl[2] = '{n: 4, a: 16'h7531, b: 16'h8642, sum: 100, cnt: 4};
        tbl[3] = '{n: 2, a: 16'h00F0, b: 16'h000F, sum: 0,   cnt: 2};
        tbl[4] = '{n: 4, a: 16'hFFFF, b: 16'h1234, sum: 150, cnt: 4};

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_trunc", out_trunc, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // Table of frames, each with latency and field checks
        for (int t = 0; t < 5; t++) begin
            send_frame(tbl[t]);
            expect_result($sformatf("tbl%0d", t), tbl[t].sum, tbl[t].cnt, 1'b0);
            release_out($sformatf("tbl%0d", t));
        end

        // Truncated frame, with the next beat waiting during HOLD
        send_uniform(16, 4'd15, 4'd15, 1'b0);
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1; in_last = 1'b1;
        expect_result("trunc", 3600, 16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_ov", out_valid, 1);
            check("hold_sum", out_sum, 3600);
            check("hold_count", out_count, 16);
            check("hold_trunc", out_trunc, 1);
            check("hold_in_ready", in_ready, 0);
        end
        release_out("trunc");
        step();
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("after_trunc", 1, 1, 1'b0);
        release_out("after_trunc");

        // in_last on the MAX_LEN-th beat is not a truncation
        send_uniform(16, 4'd1, 4'd1, 1'b1);
        expect_result("last_at_max", 16, 16, 1'b0);
        release_out("last_at_max");

        // Reset mid-frame
        send_uniform(2, 4'd5, 4'd6, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        step();
        check("midrst_ov", out_valid, 0);
        check("midrst_sum", out_sum, 0);
        check("midrst_count", out_count, 0);
        check("midrst_trunc", out_trunc, 0);
        rst = 1'b0;
        step();
        send_uniform(1, 4'd4, 4'd4, 1'b1);
        expect_result("after_rst", 16, 1, 1'b0);
        release_out("after_rst");

        // Reset while a result is held
        send_frame(tbl[0]);
        expect_result("hold_rst", 254, 3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hold_rst_ov", out_valid, 0);
        check("hold_rst_sum", out_sum, 0);
        step();
        check("hold_rst_ready", in_ready, 1);

        // Randomized traffic with idle-gap operand noise and random backpressure
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_last   = ($urandom_range(0, 6) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        begin
            int k;
            k = 0;
            while (!in_ready && k < 40) begin
                step();
                k++;
            end
            check("flush_ready_timeout", in_ready, 1);
        end
        step();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (10) step();
        out_ready = 1'b0;
        check("drain_idle_busy", m_busy, 0);
        check("drain_idle_cnt", m_cnt, 0);
        check("drain_dut_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
